// File: rtl/fetch_sequencer.sv
// Handshake-driven fetch/issue sequencer between a synchronous instruction memory
// and a multi-cycle processor: fetch (plus mvi immediate), Run pulse, wait for Done, advance.
module fetch_sequencer #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned LAST_ADDR = 31,
  parameter logic [2:0]  MVI_OP    = 3'b001,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Halt,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemQ,
  output logic [DATA_W-1:0] ProcDIN,
  output logic              ProcRun,
  input  logic              ProcDone,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              ProgDone,
  output logic              Fault
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_I, S_FETCH_D, S_ISSUE, S_EXEC, S_ADVANCE, S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halt_q, halt_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] proc_din_d;
  logic              proc_run_d, busy_d, prog_done_d, fault_d;

  logic              fetch_last, q_is_mvi, instr_is_mvi, at_last, wd_expired, prog_end;
  logic [ADDR_W:0]   span_end;
  logic [ADDR_W-1:0] pc_adv;

  assign fetch_last   = (cnt_q == CNT_W'(MEM_LAT));
  assign q_is_mvi     = (MemQ[DATA_W-1 -: 3] == MVI_OP);
  assign instr_is_mvi = (instr_q[DATA_W-1 -: 3] == MVI_OP);
  assign at_last      = (pc_q == ADDR_W'(LAST_ADDR));
  assign wd_expired   = (wd_q == WD_W'(TIMEOUT - 1));
  // Span end is computed one bit wider so an mvi at the top address cannot wrap.
  assign span_end     = {1'b0, pc_q} + (ADDR_W + 1)'(instr_is_mvi);
  assign prog_end     = (span_end >= (ADDR_W + 1)'(LAST_ADDR)) || halt_q;
  assign pc_adv       = pc_q + (instr_is_mvi ? ADDR_W'(2) : ADDR_W'(1));

  assign PC = pc_q;

  // State and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wd_q     <= '0;
      instr_q  <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      halt_q   <= 1'b0;
      MemAddr  <= '0;
      ProcDIN  <= '0;
      ProcRun  <= 1'b0;
      Busy     <= 1'b0;
      ProgDone <= 1'b0;
      Fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      instr_q  <= instr_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      halt_q   <= halt_d;
      MemAddr  <= mem_addr_d;
      ProcDIN  <= proc_din_d;
      ProcRun  <= proc_run_d;
      Busy     <= busy_d;
      ProgDone <= prog_done_d;
      Fault    <= fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (Start) state_d = S_FETCH_I;
      S_FETCH_I: begin
        if (fetch_last) begin
          if (q_is_mvi) state_d = at_last ? S_FAULT : S_FETCH_D;
          else          state_d = S_ISSUE;
        end
      end
      S_FETCH_D: if (fetch_last) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_EXEC;
      S_EXEC: begin
        if (ProcDone)        state_d = S_ADVANCE;
        else if (wd_expired) state_d = S_FAULT;
      end
      S_ADVANCE: state_d = prog_end ? S_IDLE : S_FETCH_I;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d       = '0;
    wd_d        = wd_q;
    instr_d     = instr_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    halt_d      = halt_q;
    mem_addr_d  = MemAddr;
    proc_din_d  = ProcDIN;
    proc_run_d  = (state_d == S_ISSUE);
    busy_d      = (state_d != S_IDLE) && (state_d != S_FAULT);
    prog_done_d = (state_q == S_ADVANCE) && prog_end;
    fault_d     = (state_d == S_FAULT);

    if ((state_q != S_IDLE) && (state_q != S_FAULT) && Halt) halt_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          pc_d       = '0;
          mem_addr_d = '0;
          halt_d     = 1'b0;
        end
      end
      S_FETCH_I: begin
        if (fetch_last) begin
          instr_d = MemQ;
          if (q_is_mvi && !at_last) mem_addr_d = pc_q + ADDR_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH_D: begin
        if (fetch_last) imm_d = MemQ;
        else            cnt_d = cnt_q + CNT_W'(1);
      end
      S_ISSUE: wd_d = '0;
      S_EXEC:  wd_d = wd_q + WD_W'(1);
      S_ADVANCE: begin
        pc_d = pc_adv;
        if (!prog_end) mem_addr_d = pc_adv;
      end
      default: ;
    endcase

    // Instruction goes out with Run; EXEC then holds the immediate for mvi.
    if (state_d == S_ISSUE)     proc_din_d = (state_q == S_FETCH_I) ? MemQ : instr_q;
    else if (state_d == S_EXEC) proc_din_d = instr_is_mvi ? imm_q : instr_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: registered memory model, hand-driven ProcDone/Halt,
// cycle-accurate checks of Run timing, DIN, PC, completion, halt, timeout and truncation.
module tb_fetch_sequencer;

  logic       Clock = 1'b0;
  logic       Reset, Start, Halt, ProcDone;
  logic [4:0] MemAddr, PC;
  logic [8:0] MemQ, ProcDIN;
  logic       ProcRun, Busy, ProgDone, Fault;

  logic [8:0] mem [0:31];
  int         vectors = 0;
  int         errs = 0;
  int         cyc = 0;
  int         run_cnt = 0;
  int         done_cnt = 0;
  int         run_base, done_base, n;

  fetch_sequencer #(
    .ADDR_W(5), .DATA_W(9), .MEM_LAT(1), .LAST_ADDR(2), .MVI_OP(3'b001), .TIMEOUT(15)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Halt(Halt),
    .MemAddr(MemAddr), .MemQ(MemQ), .ProcDIN(ProcDIN), .ProcRun(ProcRun),
    .ProcDone(ProcDone), .PC(PC), .Busy(Busy), .ProgDone(ProgDone), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  // One-cycle-latency synchronous memory
  always @(posedge Clock) MemQ <= mem[MemAddr];

  always @(negedge Clock) begin
    if (ProcRun === 1'b1)  run_cnt++;
    if (ProgDone === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_run(input int exp_cyc);
    int k;
    k = 0;
    while (ProcRun !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check("run_seen", 32'(ProcRun), 32'd1);
    check("run_cycle", cyc, exp_cyc);
  endtask

  // Serve one instruction: Done two cycles after Run, optional Halt alongside Done.
  task automatic do_instr(input int exp_cyc, input logic [8:0] exp_issue,
                          input logic [8:0] exp_exec, input logic with_halt);
    wait_run(exp_cyc);
    check("din_issue", 32'(ProcDIN), 32'(exp_issue));
    tick();
    check("run_low_exec", 32'(ProcRun), 32'd0);
    check("din_exec", 32'(ProcDIN), 32'(exp_exec));
    tick();
    ProcDone = 1'b1;
    Halt     = with_halt;
    tick();
    ProcDone = 1'b0;
    Halt     = 1'b0;
  endtask

  task automatic start_prog();
    Start = 1'b1;
    cyc   = 0;
    tick();
    Start = 1'b0;
    run_base  = run_cnt;
    done_base = done_cnt;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 9'o000;
    Reset = 1'b1; Start = 1'b1; Halt = 1'b0; ProcDone = 1'b0;
    tick(); tick();

    // Reset with Start held
    check("rst_memaddr", 32'(MemAddr), 32'd0);
    check("rst_din", 32'(ProcDIN), 32'd0);
    check("rst_run", 32'(ProcRun), 32'd0);
    check("rst_pc", 32'(PC), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_progdone", 32'(ProgDone), 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);

    // Three plain instructions, LAST_ADDR=2
    mem[0] = 9'o010; mem[1] = 9'o020; mem[2] = 9'o030;
    Reset = 1'b0;
    cyc = 0;
    tick();
    Start = 1'b0;
    run_base = run_cnt; done_base = done_cnt;
    check("start_memaddr", 32'(MemAddr), 32'd0);
    check("start_busy", 32'(Busy), 32'd1);
    do_instr(3, 9'o010, 9'o010, 1'b0);
    do_instr(9, 9'o020, 9'o020, 1'b0);
    do_instr(15, 9'o030, 9'o030, 1'b0);
    check("p1_progdone_adv", 32'(ProgDone), 32'd0);
    tick();
    check("p1_progdone", 32'(ProgDone), 32'd1);
    check("p1_busy_fall", 32'(Busy), 32'd0);
    check("p1_pc", 32'(PC), 32'd3);
    tick();
    check("p1_progdone_once", 32'(ProgDone), 32'd0);
    check("p1_run_count", run_cnt - run_base, 32'd3);
    check("p1_done_count", done_cnt - done_base, 32'd1);

    // mvi with immediate, then add at LAST_ADDR
    mem[0] = 9'o100; mem[1] = 9'h05A; mem[2] = 9'o210;
    start_prog();
    tick(); tick();
    check("mvi_fetch_d_addr", 32'(MemAddr), 32'd1);
    check("mvi_busy", 32'(Busy), 32'd1);
    do_instr(5, 9'o100, 9'h05A, 1'b0);
    do_instr(11, 9'o210, 9'o210, 1'b0);
    check("mvi_pc_skip", 32'(PC), 32'd2);
    check("mvi_addr", 32'(MemAddr), 32'd2);
    tick();
    check("mvi_progdone", 32'(ProgDone), 32'd1);
    check("mvi_pc_end", 32'(PC), 32'd3);

    // Halt coincident with the first ProcDone
    mem[0] = 9'o010; mem[1] = 9'o020;
    tick();
    start_prog();
    do_instr(3, 9'o010, 9'o010, 1'b1);
    check("halt_adv_pc", 32'(PC), 32'd0);
    tick();
    check("halt_progdone", 32'(ProgDone), 32'd1);
    check("halt_pc", 32'(PC), 32'd1);
    check("halt_busy", 32'(Busy), 32'd0);
    repeat (10) tick();
    check("halt_no_more_run", run_cnt - run_base, 32'd1);
    check("halt_done_count", done_cnt - done_base, 32'd1);

    // Reset mid-EXEC of the second instruction
    start_prog();
    do_instr(3, 9'o010, 9'o010, 1'b0);
    wait_run(9);
    tick();
    check("rexec_din", 32'(ProcDIN), 32'o020);
    check("rexec_pc", 32'(PC), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rexec_memaddr", 32'(MemAddr), 32'd0);
    check("rexec_din0", 32'(ProcDIN), 32'd0);
    check("rexec_pc0", 32'(PC), 32'd0);
    check("rexec_busy", 32'(Busy), 32'd0);
    check("rexec_run", 32'(ProcRun), 32'd0);

    // Watchdog timeout: no ProcDone
    tick();
    start_prog();
    wait_run(3);
    n = 0;
    while (Fault !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("to_fault_cycle", cyc, 32'd19);
    check("to_fault", 32'(Fault), 32'd1);
    check("to_busy", 32'(Busy), 32'd0);
    check("to_run", 32'(ProcRun), 32'd0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick();
    check("to_start_ignored_busy", 32'(Busy), 32'd0);
    check("to_fault_sticky", 32'(Fault), 32'd1);
    check("to_run_count", run_cnt - run_base, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("to_reset_clears", 32'(Fault), 32'd0);

    // Truncated mvi at LAST_ADDR
    mem[0] = 9'o010; mem[1] = 9'o020; mem[2] = 9'o100;
    tick();
    start_prog();
    do_instr(3, 9'o010, 9'o010, 1'b0);
    do_instr(9, 9'o020, 9'o020, 1'b0);
    n = 0;
    while (Fault !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("trunc_fault_cycle", cyc, 32'd15);
    check("trunc_pc", 32'(PC), 32'd2);
    check("trunc_memaddr", 32'(MemAddr), 32'd2);
    repeat (3) tick();
    check("trunc_run_count", run_cnt - run_base, 32'd2);
    check("trunc_no_progdone", done_cnt - done_base, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
